// File: rtl/sipo_shift_ctrl.sv
// -----------------------------------------------------------------------------
// sipo_shift_ctrl
//
// Frame sequencer for a serial-in/parallel-out shift register. A frame is
// started with start_i. WIDTH serial bits are then shifted in, LSB first. The
// captured word is rotated by a latched amount in a latched direction. Finally
// the word is offered on a valid/ready handshake. Completed handshakes are
// counted in a wrapping frame counter.
//
// Ports:
//   clock_i      rising-edge clock
//   reset_i      asynchronous active-high reset
//   start_i      begin a frame; honoured in IDLE or on the HOLD handshake edge
//   data_in_i    serial bit, consumed on each edge while shift_en_o=1
//   dir_i        rotate direction (1=right, 0=left), latched at frame start
//   rot_amt_i    rotate count 0..WIDTH-1, latched at frame start
//   shift_en_o   high in LOAD
//   busy_o       high in any state other than IDLE
//   data_out_o   internal register; meaningful while out_valid_o=1
//   out_valid_o  word available (HOLD)
//   out_ready_i  consumer accepts the word
//   frame_cnt_o  number of completed handshakes, wraps
// -----------------------------------------------------------------------------
module sipo_shift_ctrl #(
    parameter int WIDTH = 4,
    parameter int RW    = $clog2(WIDTH),
    parameter int FCW   = 8
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             data_in_i,
    input  logic             dir_i,
    input  logic [RW-1:0]    rot_amt_i,
    output logic             shift_en_o,
    output logic             busy_o,
    output logic [WIDTH-1:0] data_out_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [FCW-1:0]   frame_cnt_o
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_ROTATE = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [RW-1:0]    rot_cnt_q, rot_cnt_d;
    logic [RW-1:0]    rot_amt_q, rot_amt_d;
    logic             dir_q, dir_d;
    logic [FCW-1:0]   frame_cnt_q, frame_cnt_d;

    logic [WIDTH-1:0] rot_right;
    logic [WIDTH-1:0] rot_left;
    logic             last_bit;
    logic             handshake;

    // One-position rotations of the register, wired bit by bit.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rot
        assign rot_right[gi] = shift_q[(gi + 1) % WIDTH];
        assign rot_left[gi]  = shift_q[(gi + WIDTH - 1) % WIDTH];
    end

    assign last_bit  = (bit_cnt_q == CW'(WIDTH - 1));
    assign handshake = (state_q == S_HOLD) && out_ready_i;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (last_bit) state_d = (rot_amt_q != '0) ? S_ROTATE : S_HOLD;
            end
            S_ROTATE: begin
                // Counter holds the rotations still to perform, including this one.
                if (rot_cnt_q == RW'(1)) state_d = S_HOLD;
            end
            S_HOLD: begin
                if (out_ready_i) state_d = start_i ? S_LOAD : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Moore outputs
    // ------------------------------------------------------------------
    always_comb begin
        shift_en_o  = (state_q == S_LOAD);
        busy_o      = (state_q != S_IDLE);
        out_valid_o = (state_q == S_HOLD);
    end

    assign data_out_o  = shift_q;
    assign frame_cnt_o = frame_cnt_q;

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        rot_cnt_d   = rot_cnt_q;
        rot_amt_d   = rot_amt_q;
        dir_d       = dir_q;
        frame_cnt_d = frame_cnt_q;

        case (state_q)
            S_IDLE: begin
                // The register is intentionally left alone so data_out keeps
                // the last word while idle.
                if (start_i) begin
                    bit_cnt_d = '0;
                    dir_d     = dir_i;
                    rot_amt_d = rot_amt_i;
                end
            end
            S_LOAD: begin
                shift_d   = {data_in_i, shift_q[WIDTH-1:1]};
                bit_cnt_d = bit_cnt_q + CW'(1);
                if (last_bit) rot_cnt_d = rot_amt_q;
            end
            S_ROTATE: begin
                shift_d   = dir_q ? rot_right : rot_left;
                rot_cnt_d = rot_cnt_q - RW'(1);
            end
            S_HOLD: begin
                if (handshake) begin
                    frame_cnt_d = frame_cnt_q + FCW'(1);
                    if (start_i) begin
                        bit_cnt_d = '0;
                        dir_d     = dir_i;
                        rot_amt_d = rot_amt_i;
                    end
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            rot_cnt_q   <= '0;
            rot_amt_q   <= '0;
            dir_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            rot_cnt_q   <= rot_cnt_d;
            rot_amt_q   <= rot_amt_d;
            dir_q       <= dir_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

endmodule

// File: tb/tb_sipo_shift_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sipo_shift_ctrl
//
// Directed bench for sipo_shift_ctrl (WIDTH=4, FCW=8). Inputs are driven 1 time
// unit after each rising edge, and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_sipo_shift_ctrl;

    localparam int WIDTH = 4;
    localparam int RW    = 2;
    localparam int FCW   = 8;

    logic             clock;
    logic             reset;
    logic             start;
    logic             data_in;
    logic             dir;
    logic [RW-1:0]    rot_amt;
    logic             shift_en;
    logic             busy;
    logic [WIDTH-1:0] data_out;
    logic             out_valid;
    logic             out_ready;
    logic [FCW-1:0]   frame_cnt;

    int          checks_cnt;
    int          errors_cnt;
    logic [7:0]  exp_fc;

    sipo_shift_ctrl #(
        .WIDTH(WIDTH),
        .RW   (RW),
        .FCW  (FCW)
    ) dut (
        .clock_i    (clock),
        .reset_i    (reset),
        .start_i    (start),
        .data_in_i  (data_in),
        .dir_i      (dir),
        .rot_amt_i  (rot_amt),
        .shift_en_o (shift_en),
        .busy_o     (busy),
        .data_out_o (data_out),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .frame_cnt_o(frame_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Assumes the DUT entered LOAD on the previous edge (E0). Feeds bits[0]
    // first, waits for out_valid and checks latency and word.
    task automatic load_and_wait(input logic [3:0] bits, input int rot,
                                 input logic [3:0] exp_word, input string tag);
        int edges;
        edges = 0;
        for (int i = 0; i < WIDTH; i++) begin
            check({tag, " shift_en"}, 32'(shift_en), 32'd1);
            data_in = bits[i];
            tick();
            edges++;
        end
        data_in = 1'b0;
        check({tag, " shift_en_off"}, 32'(shift_en), 32'd0);
        while (!out_valid && edges < 20) begin
            tick();
            edges++;
        end
        check({tag, " latency"}, 32'(edges), 32'(WIDTH + rot));
        check({tag, " word"}, 32'(data_out), 32'(exp_word));
        $display("frame %s: word=%b latency=%0d frame_cnt=%0d", tag, data_out, edges, frame_cnt);
    endtask

    task automatic run_frame(input logic [3:0] bits, input logic d, input int rot,
                             input logic [3:0] exp_word, input string tag);
        start   = 1'b1;
        dir     = d;
        rot_amt = RW'(rot);
        tick();
        start   = 1'b0;
        dir     = ~d;     // must not affect the running frame
        rot_amt = RW'(rot + 1);
        check({tag, " busy"}, 32'(busy), 32'd1);
        load_and_wait(bits, rot, exp_word, tag);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        exp_fc++;
        check({tag, " frame_cnt"}, 32'(frame_cnt), 32'(exp_fc));
        check({tag, " idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        exp_fc     = 8'd0;
        start      = 1'b0;
        data_in    = 1'b0;
        dir        = 1'b0;
        rot_amt    = '0;
        out_ready  = 1'b0;
        reset      = 1'b1;
        #1;
        check("rst busy", 32'(busy), 32'd0);
        check("rst valid", 32'(out_valid), 32'd0);
        check("rst shift_en", 32'(shift_en), 32'd0);
        check("rst data", 32'(data_out), 32'd0);
        check("rst fc", 32'(frame_cnt), 32'd0);
        #12;
        reset = 1'b0;
        tick();

        // Basic frame, no rotation: 1,0,1,1 -> 1101
        run_frame(4'b1101, 1'b0, 0, 4'b1101, "basic");
        handshake("basic");

        // Rotate right by 1 and left by 2
        run_frame(4'b1101, 1'b1, 1, 4'b1110, "rr1");
        handshake("rr1");
        run_frame(4'b1101, 1'b0, 2, 4'b0111, "rl2");
        handshake("rl2");
        run_frame(4'b1101, 1'b1, 3, 4'b1011, "rr3");
        handshake("rr3");

        // Register holds last word in IDLE
        tick();
        check("idle hold word", 32'(data_out), 32'h7 ^ 32'hC);

        // Backpressure
        run_frame(4'b1101, 1'b0, 0, 4'b1101, "bp");
        for (int i = 0; i < 5; i++) begin
            data_in = i[0];
            dir     = ~i[0];
            start   = i[0];
            tick();
            check("bp word", 32'(data_out), 32'hD);
            check("bp valid", 32'(out_valid), 32'd1);
            check("bp fc", 32'(frame_cnt), 32'(exp_fc));
        end
        start = 1'b0;
        handshake("bp");

        // Back-to-back: handshake edge also starts the next frame
        run_frame(4'b1101, 1'b0, 0, 4'b1101, "b2b_a");
        out_ready = 1'b1;
        start     = 1'b1;
        dir       = 1'b0;
        rot_amt   = '0;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        exp_fc++;
        check("b2b busy", 32'(busy), 32'd1);
        check("b2b fc", 32'(frame_cnt), 32'(exp_fc));
        load_and_wait(4'b0100, 0, 4'b0100, "b2b_b");
        handshake("b2b_b");

        // Asynchronous reset mid-LOAD after two bits
        start = 1'b1;
        tick();
        start   = 1'b0;
        data_in = 1'b1;
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        exp_fc = 8'd0;
        check("arst busy", 32'(busy), 32'd0);
        check("arst shift_en", 32'(shift_en), 32'd0);
        check("arst valid", 32'(out_valid), 32'd0);
        check("arst data", 32'(data_out), 32'd0);
        check("arst fc", 32'(frame_cnt), 32'd0);
        #2;
        reset = 1'b0;
        tick();
        run_frame(4'b1010, 1'b0, 0, 4'b1010, "fresh");
        handshake("fresh");

        // frame_cnt wrap after 256 frames from reset
        for (int n = 1; n < 256; n++) begin
            run_frame(4'(n), 1'b0, 0, 4'(n), "wrap");
            handshake("wrap");
        end
        check("wrap fc zero", 32'(frame_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
